// File: rtl/counter_updn_n_if.sv
// ---------------------------------------------------------------------------
// counter_updn_n_if
// Control/data bundle for the up/down counter.
//   master : the side that drives the counter (en, up, load, set, d, cmp)
//            and observes its results (q, tc, co, match).
//   slave  : the counter itself.
// Signals:
//   en    count enable
//   up    direction (1 = increment, 0 = decrement)
//   load  parallel load request (d -> q)
//   set   force q to all ones
//   d     parallel load data, WIDTH bits
//   cmp   compare value, WIDTH bits
//   q     registered count, WIDTH bits
//   tc    terminal-count flag (combinational from q and up)
//   co    registered carry/borrow pulse
//   match registered compare flag
// ---------------------------------------------------------------------------
interface counter_updn_n_if #(
    parameter int WIDTH = 32'sd16
) ();

    logic             en;
    logic             up;
    logic             load;
    logic             set;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] cmp;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             co;
    logic             match;

    modport master (
        output en, up, load, set, d, cmp,
        input  q, tc, co, match
    );

    modport slave (
        input  en, up, load, set, d, cmp,
        output q, tc, co, match
    );

endinterface : counter_updn_n_if

// File: rtl/counter_updn_n.sv
// ---------------------------------------------------------------------------
// counter_updn_n
// Loadable up/down counter with wrap or saturate behaviour at terminal count,
// a one-cycle carry/borrow pulse and a registered compare flag.
// Parameters:
//   WIDTH     counter/data width, 2..32
//   SATURATE  0 = wrap at terminal count, 1 = hold at terminal count
//   RESET_VAL value loaded into q by reset
// Ports:
//   clk   single clock, rising edge
//   rst   synchronous active-high reset
//   bus   counter_updn_n_if.slave (en, up, load, set, d, cmp -> q, tc, co, match)
// Priority each cycle: rst > set > load > en.
// ---------------------------------------------------------------------------
module counter_updn_n #(
    parameter int               WIDTH     = 32'sd16,
    parameter int               SATURATE  = 32'sd0,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic               clk,
    input  logic               rst,
    counter_updn_n_if.slave    bus
);

    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam bit               SAT_MODE = (SATURATE != 32'sd0);

    logic [WIDTH-1:0] q_r;
    logic             co_r;
    logic             match_r;
    logic             tc_s;
    logic [WIDTH-1:0] step_q_s;
    logic [WIDTH-1:0] next_q_s;
    logic             co_next_s;

    // Terminal count: the value the next step in the current direction would wrap from.
    always_comb begin
        tc_s = 1'b0;
        if (bus.up) begin
            tc_s = (q_r == ALL_ONES);
        end else begin
            tc_s = (q_r == ZERO);
        end
    end

    // Next-state selection in priority order set > load > en; rst is applied in the register.
    always_comb begin
        step_q_s  = q_r;
        next_q_s  = q_r;
        co_next_s = 1'b0;

        // Modulo-2^WIDTH step; the direction is taken from up this very cycle.
        if (bus.up) begin
            step_q_s = q_r + ONE;
        end else begin
            step_q_s = q_r - ONE;
        end

        if (bus.set) begin
            next_q_s  = ALL_ONES;
            co_next_s = 1'b0;
        end else if (bus.load) begin
            next_q_s  = bus.d;
            co_next_s = 1'b0;
        end else if (bus.en) begin
            // The carry/borrow pulse flags a step taken at terminal count,
            // whether that step wraps or is held by saturation.
            co_next_s = tc_s;
            if (tc_s && SAT_MODE) begin
                next_q_s = q_r;
            end else begin
                next_q_s = step_q_s;
            end
        end else begin
            next_q_s  = q_r;
            co_next_s = 1'b0;
        end
    end

    // State registers; match is computed from the incoming q so it lines up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_r     <= RESET_VAL;
            co_r    <= 1'b0;
            match_r <= (RESET_VAL == bus.cmp);
        end else begin
            q_r     <= next_q_s;
            co_r    <= co_next_s;
            match_r <= (next_q_s == bus.cmp);
        end
    end

    assign bus.q     = q_r;
    assign bus.tc    = tc_s;
    assign bus.co    = co_r;
    assign bus.match = match_r;

endmodule : counter_updn_n

// File: tb/tb_counter_updn_n.sv
// ---------------------------------------------------------------------------
// tb_counter_updn_n
// Directed bench for counter_updn_n. Four instances cover the configurations
// of interest:
//   u_wrap : WIDTH=4,  SATURATE=0
//   u_sat  : WIDTH=4,  SATURATE=1
//   u_w16  : WIDTH=16, SATURATE=0
//   u_rv   : WIDTH=4,  SATURATE=0, RESET_VAL=4'hA
// Inputs change #1 after a rising edge; outputs are checked at that point too.
// ---------------------------------------------------------------------------
module tb_counter_updn_n;

    logic clk;
    logic rst_a;
    logic rst_b;
    logic rst_c;
    logic rst_d;

    int n_checks;
    int n_fail;

    counter_updn_n_if #(.WIDTH(4))  if_a ();
    counter_updn_n_if #(.WIDTH(4))  if_b ();
    counter_updn_n_if #(.WIDTH(16)) if_c ();
    counter_updn_n_if #(.WIDTH(4))  if_d ();

    counter_updn_n #(.WIDTH(4), .SATURATE(0)) u_wrap (
        .clk (clk),
        .rst (rst_a),
        .bus (if_a.slave)
    );

    counter_updn_n #(.WIDTH(4), .SATURATE(1)) u_sat (
        .clk (clk),
        .rst (rst_b),
        .bus (if_b.slave)
    );

    counter_updn_n #(.WIDTH(16), .SATURATE(0)) u_w16 (
        .clk (clk),
        .rst (rst_c),
        .bus (if_c.slave)
    );

    counter_updn_n #(.WIDTH(4), .SATURATE(0), .RESET_VAL(4'hA)) u_rv (
        .clk (clk),
        .rst (rst_d),
        .bus (if_d.slave)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Directed stimulus and checks.
    initial begin
        n_checks = 0;
        n_fail   = 0;

        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1; rst_d = 1'b1;
        if_a.en = 1'b0; if_a.up = 1'b0; if_a.load = 1'b0; if_a.set = 1'b0; if_a.d = 4'h0;  if_a.cmp = 4'h0;
        if_b.en = 1'b0; if_b.up = 1'b0; if_b.load = 1'b0; if_b.set = 1'b0; if_b.d = 4'h0;  if_b.cmp = 4'h0;
        if_c.en = 1'b0; if_c.up = 1'b0; if_c.load = 1'b0; if_c.set = 1'b0; if_c.d = 16'h0; if_c.cmp = 16'h0;
        if_d.en = 1'b1; if_d.up = 1'b1; if_d.load = 1'b1; if_d.set = 1'b1; if_d.d = 4'h3;  if_d.cmp = 4'hA;

        // Reset state (u_rv has every control asserted: reset must win).
        tick();
        chk("rst_a_q",     32'(if_a.q),     32'h0);
        chk("rst_a_co",    32'(if_a.co),    32'h0);
        chk("rst_a_match", 32'(if_a.match), 32'h1);
        chk("rst_a_tc",    32'(if_a.tc),    32'h1);
        chk("rst_rv_q",    32'(if_d.q),     32'hA);
        chk("rst_rv_match",32'(if_d.match), 32'h1);
        chk("rst_rv_tc",   32'(if_d.tc),    32'h0);

        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0; rst_d = 1'b0;
        // First step after reset starts from RESET_VAL.
        if_d.set = 1'b0; if_d.load = 1'b0; if_d.en = 1'b1; if_d.up = 1'b0;
        // Wrap up on u_wrap: load 14 first.
        if_a.load = 1'b1; if_a.d = 4'd14;
        tick();
        chk("rv_first_step_q", 32'(if_d.q),     32'h9);
        chk("rv_first_match",  32'(if_d.match), 32'h0);
        chk("wrap_load_q",     32'(if_a.q),     32'd14);
        if_d.en = 1'b0;

        if_a.load = 1'b0; if_a.en = 1'b1; if_a.up = 1'b1;
        #1;
        chk("wrap_tc_14", 32'(if_a.tc), 32'h0);
        tick();
        chk("wrap_q_15",  32'(if_a.q),  32'd15);
        chk("wrap_tc_15", 32'(if_a.tc), 32'h1);
        chk("wrap_co_15", 32'(if_a.co), 32'h0);
        tick();
        chk("wrap_q_0",   32'(if_a.q),  32'd0);
        chk("wrap_co_0",  32'(if_a.co), 32'h1);
        chk("wrap_tc_0",  32'(if_a.tc), 32'h0);
        tick();
        chk("wrap_q_1",   32'(if_a.q),  32'd1);
        chk("wrap_co_1",  32'(if_a.co), 32'h0);

        // Priority: set beats load and en.
        if_a.set = 1'b1; if_a.load = 1'b1; if_a.d = 4'd5; if_a.en = 1'b1;
        tick();
        chk("prio_set_q",  32'(if_a.q),  32'd15);
        chk("prio_set_co", 32'(if_a.co), 32'h0);
        // Set again while q sits at terminal count with en=1: still no carry pulse.
        tick();
        chk("prio_set_tc_co", 32'(if_a.co), 32'h0);
        if_a.set = 1'b0;
        tick();
        chk("prio_load_q",  32'(if_a.q),  32'd5);
        chk("prio_load_co", 32'(if_a.co), 32'h0);

        // Compare: match aligns with the q it describes.
        if_a.load = 1'b0; if_a.cmp = 4'd7; if_a.en = 1'b1; if_a.up = 1'b1;
        tick();
        chk("cmp_q_6",     32'(if_a.q),     32'd6);
        chk("cmp_match_6", 32'(if_a.match), 32'h0);
        tick();
        chk("cmp_q_7",     32'(if_a.q),     32'd7);
        chk("cmp_match_7", 32'(if_a.match), 32'h1);
        tick();
        chk("cmp_q_8",     32'(if_a.q),     32'd8);
        chk("cmp_match_8", 32'(if_a.match), 32'h0);
        // cmp change with en=0: q holds, match follows cmp one cycle later.
        if_a.en = 1'b0; if_a.cmp = 4'd8;
        tick();
        chk("hold_q_8",      32'(if_a.q),     32'd8);
        chk("cmp_new_match", 32'(if_a.match), 32'h1);

        // Wrap down: 0 -> 15 with a borrow pulse.
        if_a.load = 1'b1; if_a.d = 4'd0;
        tick();
        chk("down_load_q", 32'(if_a.q), 32'd0);
        if_a.load = 1'b0; if_a.en = 1'b1; if_a.up = 1'b0;
        #1;
        chk("down_tc_0", 32'(if_a.tc), 32'h1);
        tick();
        chk("down_wrap_q",  32'(if_a.q),  32'd15);
        chk("down_wrap_co", 32'(if_a.co), 32'h1);

        // Reset mid-count aborts the step and outranks set.
        if_a.load = 1'b1; if_a.d = 4'd9; if_a.en = 1'b0;
        tick();
        if_a.load = 1'b0; if_a.en = 1'b1; if_a.up = 1'b1;
        tick();
        chk("midrst_pre_q", 32'(if_a.q), 32'd10);
        rst_a = 1'b1; if_a.set = 1'b1; if_a.cmp = 4'd0;
        tick();
        chk("midrst_q",     32'(if_a.q),     32'd0);
        chk("midrst_co",    32'(if_a.co),    32'h0);
        chk("midrst_match", 32'(if_a.match), 32'h1);
        // tc stays live during reset: q=0 with up=0 is terminal.
        if_a.up = 1'b0;
        #1;
        chk("midrst_tc", 32'(if_a.tc), 32'h1);
        tick();
        rst_a = 1'b0; if_a.set = 1'b0; if_a.en = 1'b1; if_a.up = 1'b1;
        tick();
        chk("postrst_q",  32'(if_a.q),  32'd1);
        chk("postrst_co", 32'(if_a.co), 32'h0);

        // Saturate down on u_sat: 1 -> 0, 0, 0; co in 2nd and 3rd cycles.
        if_b.load = 1'b1; if_b.d = 4'd1;
        tick();
        if_b.load = 1'b0; if_b.en = 1'b1; if_b.up = 1'b0;
        tick();
        chk("sat_dn_q_1",  32'(if_b.q),  32'd0);
        chk("sat_dn_co_1", 32'(if_b.co), 32'h0);
        tick();
        chk("sat_dn_q_2",  32'(if_b.q),  32'd0);
        chk("sat_dn_co_2", 32'(if_b.co), 32'h1);
        tick();
        chk("sat_dn_q_3",  32'(if_b.q),  32'd0);
        chk("sat_dn_co_3", 32'(if_b.co), 32'h1);
        if_b.up = 1'b1;
        tick();
        chk("sat_rev_q",  32'(if_b.q),  32'd1);
        chk("sat_rev_co", 32'(if_b.co), 32'h0);
        // Saturate up at 15.
        if_b.en = 1'b0; if_b.load = 1'b1; if_b.d = 4'd15;
        tick();
        chk("sat_ld15_co", 32'(if_b.co), 32'h0);
        if_b.load = 1'b0; if_b.en = 1'b1; if_b.up = 1'b1;
        tick();
        chk("sat_up_q",  32'(if_b.q),  32'd15);
        chk("sat_up_co", 32'(if_b.co), 32'h1);
        if_b.en = 1'b0;
        tick();
        chk("sat_idle_co", 32'(if_b.co), 32'h0);

        // Direction reversal on the 16-bit counter.
        if_c.load = 1'b1; if_c.d = 16'h0001;
        tick();
        if_c.load = 1'b0; if_c.en = 1'b1; if_c.up = 1'b0;
        tick();
        chk("dir_q_0",  32'(if_c.q),  32'h0000);
        chk("dir_co_0", 32'(if_c.co), 32'h0);
        if_c.up = 1'b1;
        tick();
        chk("dir_q_1",  32'(if_c.q),  32'h0001);
        chk("dir_co_1", 32'(if_c.co), 32'h0);
        // 16-bit wrap up.
        if_c.en = 1'b0; if_c.load = 1'b1; if_c.d = 16'hFFFF;
        tick();
        if_c.load = 1'b0; if_c.en = 1'b1; if_c.up = 1'b1;
        #1;
        chk("w16_tc_ffff", 32'(if_c.tc), 32'h1);
        tick();
        chk("w16_wrap_q",  32'(if_c.q),  32'h0000);
        chk("w16_wrap_co", 32'(if_c.co), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_counter_updn_n

// File: doc/counter_updn_n.md
COUNTER_UPDN_N -- requirements
Module: counter_updn_n

Interface
REQ-001 Parameter WIDTH, default 16: counter and data width in bits; legal range 2..32.
REQ-002 Parameter SATURATE, default 0: 0 = wrap at terminal count, 1 = hold at terminal count.
REQ-003 Parameter RESET_VAL, default 0: value loaded into q by reset; width WIDTH.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 en  input  1  count enable; one step per cycle when high.
REQ-007 up  input  1  direction; 1 = increment, 0 = decrement.
REQ-008 load  input  1  parallel load request.
REQ-009 set  input  1  force all ones.
REQ-010 d  input  WIDTH  parallel load data.
REQ-011 cmp  input  WIDTH  compare value.
REQ-012 q  output  WIDTH  registered count value.
REQ-013 tc  output  1  terminal-count flag, combinational from q and up.
REQ-014 co  output  1  registered carry/borrow pulse.
REQ-015 match  output  1  registered compare flag.

Function
REQ-016 Per-cycle priority SHALL be rst > set > load > en; lower-priority requests in the same cycle SHALL be ignored.
REQ-017 set=1 SHALL make q = all ones on the next edge.
REQ-018 load=1 (set=0) SHALL make q = d on the next edge.
REQ-019 en=1 with set=0 and load=0 SHALL step q by exactly 1 in the direction given by up, modulo 2^WIDTH.
REQ-020 en=0 with set=0 and load=0 SHALL hold q.
REQ-021 tc SHALL be 1 when up=1 and q = 2^WIDTH-1, or when up=0 and q = 0; otherwise 0.
REQ-022 SATURATE=0: a step taken while tc=1 SHALL wrap q (all ones to 0 going up; 0 to all ones going down).
REQ-023 SATURATE=1: a step taken while tc=1 SHALL leave q unchanged.
REQ-024 co SHALL be 1 for exactly the one cycle following an edge on which a step was taken with tc=1, in both modes; otherwise co SHALL be 0.
REQ-025 co SHALL be 0 after set or load edges, even when the loaded value equals a terminal value.
REQ-026 match SHALL be registered as (next q == cmp), so that match aligns with the q it describes.
REQ-027 Direction change on up SHALL take effect on the same cycle, with no pipeline penalty.
REQ-028 Latency from any control input to q SHALL be 1 clock cycle.
REQ-029 cmp changes SHALL be reflected in match one cycle later.

Reset
REQ-030 rst=1 SHALL set q = RESET_VAL, co = 0 and match = (RESET_VAL == cmp) on the next edge, regardless of every other input.
REQ-031 Reset asserted mid-count SHALL abort any pending step.
REQ-032 The first step after rst deasserts SHALL start from RESET_VAL.
REQ-033 tc SHALL remain combinationally valid during reset.

Verification
REQ-034 Wrap up (WIDTH=4, SATURATE=0): q=14, en=1, up=1 for 3 cycles -> q 15, 0, 1; tc=1 while q=15; co=1 only in the cycle q=0.
REQ-035 Saturate down (WIDTH=4, SATURATE=1): q=1, en=1, up=0 for 3 cycles -> q 0, 0, 0; co=1 in the 2nd and 3rd cycles after the first step.
REQ-036 Priority: set=1, load=1, d=5, en=1 -> q=15 (WIDTH=4), co=0; next cycle load=1, d=5, en=1 -> q=5.
REQ-037 Compare: cmp=7, q=5, up=1, en=1 -> match=1 in the same cycle q becomes 7; match=0 when q=8.
REQ-038 Reset mid-count: q=9 counting up, rst=1 with en=1 and set=1 -> q=RESET_VAL (0), co=0; after release, en=1 -> q=1.
REQ-039 Direction reversal (WIDTH=16): q=0x0001, up=0 -> q=0x0000; next cycle up=1 -> q=0x0001; co stays 0 throughout.
